// File: rtl/emu_clock_reset_seq.sv
// Reset sequencer and phi1/phi2 phase generator for the emulation clock domain.
// Filters DCM lock and board reset, then releases staged resets aligned to phi1.
module emu_clock_reset_seq #(
   parameter int HALFCYCLE = 30,
   parameter int STRETCH   = 8,
   parameter int LOCK_FILT = 4,
   parameter int NCH       = 2,
   parameter int STAGE_GAP = 4
) (
   input  logic           eclk,
   input  logic           ereset_n,
   input  logic           dcm_locked,
   input  logic           ext_res_n,
   output logic           ph_tick,
   output logic           phase,
   output logic [NCH-1:0] rst_out,
   output logic           ready,
   output logic [7:0]     relock_cnt
);

   localparam int HCW = (HALFCYCLE > 1) ? $clog2(HALFCYCLE) : 1;
   localparam int SCW = (STRETCH   > 1) ? $clog2(STRETCH)   : 1;
   localparam int GCW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam int CHW = (NCH       > 1) ? $clog2(NCH)       : 1;
   localparam int LKW = $clog2(LOCK_FILT + 1);

   typedef enum logic [2:0] {
      S_WAIT    = 3'd0,
      S_STRETCH = 3'd1,
      S_ALIGN   = 3'd2,
      S_STAGGER = 3'd3,
      S_RUN     = 3'd4
   } state_t;

   logic [HCW-1:0] r_hcnt;
   logic           r_phase;
   logic           w_tick;
   logic [1:0]     r_lk_sync;
   logic [1:0]     r_res_sync;
   logic [LKW-1:0] r_lk_cnt;
   logic [LKW-1:0] w_lk_nxt;
   logic           w_good;

   state_t         r_state,  w_state_nxt;
   logic [SCW-1:0] r_scnt,   w_scnt_nxt;
   logic [GCW-1:0] r_gcnt,   w_gcnt_nxt;
   logic [CHW-1:0] r_ch,     w_ch_nxt;
   logic [NCH-1:0] r_rst,    w_rst_nxt;
   logic [7:0]     r_relock, w_relock_nxt;

   // Free-running half-cycle counter; only ereset_n ever disturbs it.
   assign w_tick = (r_hcnt == HCW'(HALFCYCLE - 1));

   always_ff @(posedge eclk or negedge ereset_n) begin
      if (!ereset_n) begin
         r_hcnt  <= '0;
         r_phase <= 1'b0;
      end else if (w_tick) begin
         r_hcnt  <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_hcnt  <= r_hcnt + HCW'(1);
      end
   end

   always_ff @(posedge eclk or negedge ereset_n) begin
      if (!ereset_n) begin
         r_lk_sync  <= 2'b00;
         r_res_sync <= 2'b00;
         r_lk_cnt   <= '0;
      end else begin
         r_lk_sync  <= {r_lk_sync[0], dcm_locked};
         r_res_sync <= {r_res_sync[0], ext_res_n};
         r_lk_cnt   <= w_lk_nxt;
      end
   end

   // good looks at the filter's next value so it rises on the qualifying sample
   // and falls on the very first synced low, giving a one-cycle reaction.
   always_comb begin
      w_lk_nxt = '0;
      if (r_lk_sync[1])
         w_lk_nxt = (r_lk_cnt == LKW'(LOCK_FILT)) ? r_lk_cnt : r_lk_cnt + LKW'(1);
   end

   assign w_good = (w_lk_nxt == LKW'(LOCK_FILT)) & r_res_sync[1];

   always_comb begin
      w_state_nxt  = r_state;
      w_scnt_nxt   = r_scnt;
      w_gcnt_nxt   = r_gcnt;
      w_ch_nxt     = r_ch;
      w_rst_nxt    = r_rst;
      w_relock_nxt = r_relock;
      if (!w_good) begin
         // Loss of good beats any release scheduled for this cycle.
         w_state_nxt = S_WAIT;
         w_rst_nxt   = '1;
         w_scnt_nxt  = '0;
         w_gcnt_nxt  = '0;
         w_ch_nxt    = '0;
         if (r_state == S_RUN && !r_lk_sync[1] && r_relock != 8'hFF)
            w_relock_nxt = r_relock + 8'd1;
      end else begin
         case (r_state)
            S_WAIT: begin
               w_state_nxt = S_STRETCH;
               w_scnt_nxt  = '0;
            end
            S_STRETCH: begin
               if (r_scnt == SCW'(STRETCH - 1)) w_state_nxt = S_ALIGN;
               else                             w_scnt_nxt  = r_scnt + SCW'(1);
            end
            S_ALIGN: begin
               // End of phi2: the registered release lands on the first phi1 cycle.
               if (w_tick && r_phase) begin
                  w_rst_nxt[0] = 1'b0;
                  w_gcnt_nxt   = '0;
                  w_ch_nxt     = CHW'(1);
                  w_state_nxt  = (NCH == 1) ? S_RUN : S_STAGGER;
               end
            end
            S_STAGGER: begin
               if (r_gcnt == GCW'(STAGE_GAP - 1)) begin
                  w_gcnt_nxt = '0;
                  for (int i = 1; i < NCH; i++)
                     if (r_ch == CHW'(i)) w_rst_nxt[i] = 1'b0;
                  if (r_ch == CHW'(NCH - 1)) w_state_nxt = S_RUN;
                  else                       w_ch_nxt    = r_ch + CHW'(1);
               end else begin
                  w_gcnt_nxt = r_gcnt + GCW'(1);
               end
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_WAIT;
         endcase
      end
   end

   always_ff @(posedge eclk or negedge ereset_n) begin
      if (!ereset_n) begin
         r_state  <= S_WAIT;
         r_scnt   <= '0;
         r_gcnt   <= '0;
         r_ch     <= '0;
         r_rst    <= '1;
         r_relock <= 8'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_scnt   <= w_scnt_nxt;
         r_gcnt   <= w_gcnt_nxt;
         r_ch     <= w_ch_nxt;
         r_rst    <= w_rst_nxt;
         r_relock <= w_relock_nxt;
      end
   end

   assign ph_tick    = w_tick;
   assign phase      = r_phase;
   assign rst_out    = r_rst;
   assign ready      = (r_state == S_RUN);
   assign relock_cnt = r_relock;

endmodule

// File: tb/tb_emu_clock_reset_seq.sv
// Directed bench for emu_clock_reset_seq: expected {rst_out,ready} transitions are
// queued with their cycle when stimulus is applied and matched as they appear.
module tb_emu_clock_reset_seq;

   logic       eclk = 1'b0;
   logic       ereset_n, dcm_locked, ext_res_n;
   logic       ph_tick, phase, ready;
   logic [2:0] rst_out;
   logic [7:0] relock_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;
   logic [3:0] prev;

   typedef struct { int cyc; logic [3:0] val; } ev_t;
   ev_t q[$];

   emu_clock_reset_seq #(
      .HALFCYCLE(3), .STRETCH(4), .LOCK_FILT(2), .NCH(3), .STAGE_GAP(2)
   ) dut (
      .eclk(eclk), .ereset_n(ereset_n), .dcm_locked(dcm_locked), .ext_res_n(ext_res_n),
      .ph_tick(ph_tick), .phase(phase), .rst_out(rst_out), .ready(ready),
      .relock_cnt(relock_cnt)
   );

   always #5 eclk = ~eclk;

   // Cycle n = state after the n-th rising edge since reset release.
   always @(posedge eclk or negedge ereset_n)
      if (!ereset_n) cyc = 0;
      else           cyc = cyc + 1;

   always @(negedge eclk) begin
      logic [3:0] cur;
      ev_t e;
      if (mon_en) begin
         cur = {rst_out, ready};
         if (cur !== prev) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $error("FAIL unexpected_change: got %b at cyc %0d, required no change", cur, cyc);
            end else begin
               e = q.pop_front();
               assert (cur === e.val && cyc == e.cyc) else begin
                  errors++;
                  $error("FAIL transition: got %b at cyc %0d, required %b at cyc %0d",
                         cur, cyc, e.val, e.cyc);
               end
            end
         end
         prev = cur;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
      end
   endtask

   // Release schedule after good rises in cycle g: stretch, then first phi1 start.
   function automatic int push_seq(input int g);
      int r;
      r = g + 6;
      while (r % 6 != 0) r++;
      q.push_back('{r,     4'b1100});
      q.push_back('{r + 2, 4'b1000});
      q.push_back('{r + 4, 4'b0001});
      return r;
   endfunction

   task automatic wait_empty();
      int t = 0;
      while (q.size() != 0 && t < 200) begin
         @(negedge eclk);
         t++;
      end
      chk("seq_timeout", q.size(), 0);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge eclk);
   endtask

   initial begin
      int n, r;
      ereset_n = 1'b1; dcm_locked = 1'b0; ext_res_n = 1'b0;
      #1 ereset_n = 1'b0;
      #1;
      chk("rst_rst_out", rst_out, 3'b111);
      chk("rst_ready", ready, 0);
      chk("rst_ph_tick", ph_tick, 0);
      chk("rst_phase", phase, 0);
      chk("rst_relock", relock_cnt, 0);
      repeat (2) @(negedge eclk);
      ereset_n = 1'b1;
      prev = 4'b1110;
      mon_en = 1'b1;

      // Phase generator with inputs low
      repeat (12) begin
         chk("ph_tick", ph_tick, (cyc % 3) == 2);
         chk("phase", phase, (cyc / 3) % 2);
         chk("idle_ready", ready, 0);
         @(negedge eclk);
      end

      // One-cycle lock glitch must not qualify
      ext_res_n = 1'b1; dcm_locked = 1'b1;
      @(negedge eclk);
      dcm_locked = 1'b0;
      repeat (8) @(negedge eclk);
      chk("glitch_rst_out", rst_out, 3'b111);
      chk("glitch_ready", ready, 0);

      // Bring-up
      n = cyc;
      dcm_locked = 1'b1;
      r = push_seq(n + 3);
      wait_empty();
      chk("bringup_relock", relock_cnt, 0);

      // Lock loss in RUN
      n = cyc;
      dcm_locked = 1'b0;
      @(negedge eclk);
      dcm_locked = 1'b1;
      q.push_back('{n + 3, 4'b1110});
      r = push_seq(n + 4);
      repeat (2) @(negedge eclk);
      chk("loss_relock", relock_cnt, 1);
      wait_empty();

      // Board reset pulse in RUN
      n = cyc;
      ext_res_n = 1'b0;
      @(negedge eclk);
      ext_res_n = 1'b1;
      q.push_back('{n + 3, 4'b1110});
      r = push_seq(n + 3);
      // Board reset colliding with the last channel release: drop wins
      wait_cyc(r + 1);
      ext_res_n = 1'b0;
      @(negedge eclk);
      ext_res_n = 1'b1;
      void'(q.pop_back());
      q.push_back('{r + 4, 4'b1110});
      r = push_seq(r + 4);
      wait_empty();
      chk("board_res_relock", relock_cnt, 1);

      // Repeated lock losses until saturation
      for (int k = 2; k <= 257; k++) begin
         n = cyc;
         dcm_locked = 1'b0;
         @(negedge eclk);
         dcm_locked = 1'b1;
         q.push_back('{n + 3, 4'b1110});
         r = push_seq(n + 4);
         repeat (2) @(negedge eclk);
         chk("sat_relock", relock_cnt, (k > 255) ? 255 : k);
         wait_empty();
      end

      // Asynchronous reset mid-RUN, sampled before any clock edge
      mon_en = 1'b0;
      #2 ereset_n = 1'b0;
      #1;
      chk("async_rst_out", rst_out, 3'b111);
      chk("async_ready", ready, 0);
      chk("async_ph_tick", ph_tick, 0);
      chk("async_phase", phase, 0);
      chk("async_relock", relock_cnt, 0);
      chk("queue_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
